// File: rtl/ps2_keyboard_port.sv
// PS/2 keyboard receiver. It decodes scan codes into Dir/Dat/Commit registers,
// which a soft processor reads through a Port_ID/Read_Strobe input bus.
module ps2_keyboard_port #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] Port_ID,
    input  logic       Read_Strobe,
    output logic [7:0] Keyboard_Output,
    input  logic       PS2_Clock,
    input  logic       PS2_Data
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    // Index 0 is the PS/2 clock line and index 1 is the PS/2 data line.
    logic [1:0]    meta_q, sync_q, filt_q, filt_d;
    logic [FW-1:0] fcnt_q [2];
    logic [FW-1:0] fcnt_d [2];
    logic          fall_s;

    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [9:0]    shift_q, shift_d;
    logic [TW-1:0] to_q, to_d;
    logic          byte_vld_q, byte_vld_d;
    logic [7:0]    byte_q, byte_d;

    logic          ext_q, ext_d, brk_q, brk_d, pend_q, pend_d, commit_q, commit_d;
    logic [7:0]    dir_q, dir_d, dat_q, dat_d;
    logic [3:0]    fkey_s;
    logic [4:0]    digit_s;

    function automatic logic [3:0] fkey_index(input logic [7:0] code);
        case (code)
            8'h05:   fkey_index = 4'd1;
            8'h06:   fkey_index = 4'd2;
            8'h04:   fkey_index = 4'd3;
            8'h0C:   fkey_index = 4'd4;
            8'h03:   fkey_index = 4'd5;
            8'h0B:   fkey_index = 4'd6;
            8'h83:   fkey_index = 4'd7;
            8'h0A:   fkey_index = 4'd8;
            8'h01:   fkey_index = 4'd9;
            8'h09:   fkey_index = 4'd10;
            default: fkey_index = 4'd0;
        endcase
    endfunction

    // Bit 4 of the result flags a digit key.
    function automatic logic [4:0] digit_value(input logic [7:0] code);
        case (code)
            8'h45:   digit_value = 5'h10;
            8'h16:   digit_value = 5'h11;
            8'h1E:   digit_value = 5'h12;
            8'h26:   digit_value = 5'h13;
            8'h25:   digit_value = 5'h14;
            8'h2E:   digit_value = 5'h15;
            8'h36:   digit_value = 5'h16;
            8'h3D:   digit_value = 5'h17;
            8'h3E:   digit_value = 5'h18;
            8'h46:   digit_value = 5'h19;
            default: digit_value = 5'h00;
        endcase
    endfunction

    // Glitch filter: a line takes a new level only after FILTER_LEN consecutive differing samples.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < 2; i++) begin
            fcnt_d[i] = {FW{1'b0}};
            if (sync_q[i] != filt_q[i]) begin
                if (fcnt_q[i] == FW'(FILTER_LEN - 1)) begin
                    filt_d[i] = sync_q[i];
                end else begin
                    fcnt_d[i] = fcnt_q[i] + FW'(1);
                end
            end else begin
                fcnt_d[i] = {FW{1'b0}};
            end
        end
    end

    assign fall_s = filt_q[0] & ~filt_d[0];

    // Frame assembly: start and data bits shift in from the top, and the 11th edge checks the stop bit.
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        to_d       = to_q;
        byte_d     = byte_q;
        byte_vld_d = 1'b0;
        if (fall_s) begin
            to_d = {TW{1'b0}};
            if (bit_cnt_q == 4'd10) begin
                bit_cnt_d = 4'd0;
                if (shift_q[0] == 1'b0 && filt_q[1] == 1'b1) begin
                    byte_vld_d = 1'b1;
                    byte_d     = shift_q[8:1];
                end else begin
                    byte_vld_d = 1'b0;
                end
            end else begin
                shift_d   = {filt_q[1], shift_q[9:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else if (bit_cnt_q != 4'd0) begin
            if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
                bit_cnt_d = 4'd0;
                to_d      = {TW{1'b0}};
            end else begin
                to_d = to_q + TW'(1);
            end
        end else begin
            to_d = {TW{1'b0}};
        end
    end

    // Register updates. A read-clear is applied before a decode that lands in the same cycle.
    always_comb begin
        fkey_s   = fkey_index(byte_q);
        digit_s  = digit_value(byte_q);
        ext_d    = ext_q;
        brk_d    = brk_q;
        pend_d   = pend_q;
        dir_d    = dir_q;
        dat_d    = dat_q;
        commit_d = commit_q;
        if (Read_Strobe && Port_ID == 8'h07 && commit_q) begin
            pend_d = 1'b1;
        end else if (pend_q && !Read_Strobe) begin
            pend_d   = 1'b0;
            dir_d    = 8'h00;
            dat_d    = 8'h00;
            commit_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end
        if (byte_vld_q) begin
            case (byte_q)
                8'hE0: ext_d = 1'b1;
                8'hF0: brk_d = 1'b1;
                default: begin
                    if (ext_q || brk_q) begin
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                    end else if (fkey_s != 4'd0) begin
                        dir_d = {4'd0, fkey_s};
                        dat_d = 8'h00;
                    end else if (byte_q == 8'h78) begin
                        dir_d    = 8'h0B;
                        commit_d = 1'b1;
                    end else if (byte_q == 8'h07) begin
                        dir_d    = 8'h0C;
                        commit_d = 1'b1;
                    end else if (digit_s[4]) begin
                        if (!commit_d) begin
                            dat_d = {dat_d[3:0], digit_s[3:0]};
                        end else begin
                            dat_d = dat_d;
                        end
                    end else if (byte_q == 8'h5A) begin
                        if (dir_d != 8'h00) begin
                            commit_d = 1'b1;
                        end else begin
                            commit_d = commit_d;
                        end
                    end else begin
                        dir_d = dir_d;
                    end
                end
            endcase
        end else begin
            ext_d = ext_q;
        end
    end

    // State register with a synchronous active-low reset. The input lines reset to their idle-high level.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            meta_q     <= 2'b11;
            sync_q     <= 2'b11;
            filt_q     <= 2'b11;
            fcnt_q[0]  <= {FW{1'b0}};
            fcnt_q[1]  <= {FW{1'b0}};
            bit_cnt_q  <= 4'd0;
            shift_q    <= 10'd0;
            to_q       <= {TW{1'b0}};
            byte_vld_q <= 1'b0;
            byte_q     <= 8'h00;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            pend_q     <= 1'b0;
            dir_q      <= 8'h00;
            dat_q      <= 8'h00;
            commit_q   <= 1'b0;
        end else begin
            meta_q     <= {PS2_Data, PS2_Clock};
            sync_q     <= meta_q;
            filt_q     <= filt_d;
            fcnt_q[0]  <= fcnt_d[0];
            fcnt_q[1]  <= fcnt_d[1];
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            to_q       <= to_d;
            byte_vld_q <= byte_vld_d;
            byte_q     <= byte_d;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            pend_q     <= pend_d;
            dir_q      <= dir_d;
            dat_q      <= dat_d;
            commit_q   <= commit_d;
        end
    end

    // The read mux is combinational from the registers.
    always_comb begin
        case (Port_ID)
            8'h05:   Keyboard_Output = dir_q;
            8'h06:   Keyboard_Output = dat_q;
            8'h07:   Keyboard_Output = {7'd0, commit_q};
            default: Keyboard_Output = 8'h00;
        endcase
    end
endmodule

// File: tb/tb_ps2_keyboard_port.sv
// Scoreboard bench: read tasks queue the expected data, and a negedge monitor compares each strobed cycle.
module tb_ps2_keyboard_port;
    localparam int HALF_NS = 200;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [7:0] Port_ID = 8'h00;
    logic       Read_Strobe = 1'b0;
    logic [7:0] Keyboard_Output;
    logic       PS2_Clock = 1'b1;
    logic       PS2_Data = 1'b1;

    typedef struct { logic [7:0] port; logic [7:0] exp; } exp_t;
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    ps2_keyboard_port #(.FILTER_LEN(8), .TIMEOUT_CYCLES(300)) dut (
        .CLK(CLK), .RESET(RESET), .Port_ID(Port_ID), .Read_Strobe(Read_Strobe),
        .Keyboard_Output(Keyboard_Output), .PS2_Clock(PS2_Clock), .PS2_Data(PS2_Data)
    );

    always #5 CLK = ~CLK;

    // Monitor: every cycle that has the strobe high is one scoreboard comparison.
    always @(negedge CLK) begin
        if (Read_Strobe) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_read port=%h got=%h required=none", Port_ID, Keyboard_Output);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (Keyboard_Output === e.exp) n_pass++;
                else $display("FAIL read_port_%h got=%h required=%h", e.port, Keyboard_Output, e.exp);
            end
        end
    end

    task automatic rd(input logic [7:0] id, input logic [7:0] exp);
        exp_t e;
        e.port = id;
        e.exp = exp;
        @(posedge CLK); #1;
        Port_ID = id;
        Read_Strobe = 1'b1;
        exp_q.push_back(e);
        exp_q.push_back(e);
        repeat (2) @(posedge CLK);
        #1 Read_Strobe = 1'b0;
        repeat (3) @(posedge CLK);
    endtask

    task automatic send_bits(input logic [7:0] b, input logic stop, input int nbits);
        logic [10:0] f;
        f = {stop, ~^b, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            PS2_Data = f[i];
            #(HALF_NS);
            PS2_Clock = 1'b0;
            #(HALF_NS);
            PS2_Clock = 1'b1;
        end
        PS2_Data = 1'b1;
        #(4 * HALF_NS);
    endtask

    task automatic key(input logic [7:0] b);
        send_bits(b, 1'b1, 11);
        send_bits(8'hF0, 1'b1, 11);
        send_bits(b, 1'b1, 11);
    endtask

    initial begin
        repeat (5) @(posedge CLK);
        #1 RESET = 1'b1;
        repeat (3) @(posedge CLK);
        rd(8'h05, 8'h00); rd(8'h06, 8'h00); rd(8'h07, 8'h00); rd(8'h00, 8'h00);

        key(8'h78);
        rd(8'h05, 8'h0B); rd(8'h06, 8'h00); rd(8'h07, 8'h01);
        rd(8'h05, 8'h00); rd(8'h06, 8'h00); rd(8'h07, 8'h00);

        key(8'h05);
        rd(8'h05, 8'h01); rd(8'h06, 8'h00); rd(8'h07, 8'h00);

        key(8'h1E);
        rd(8'h06, 8'h02);
        key(8'h16);
        rd(8'h06, 8'h21); rd(8'h05, 8'h01);

        key(8'h5A);
        rd(8'h05, 8'h01); rd(8'h06, 8'h21); rd(8'h07, 8'h01);
        #1000;
        rd(8'h05, 8'h00); rd(8'h06, 8'h00); rd(8'h07, 8'h00);

        // Enter with no selection, then an extended prefix that swallows the next code.
        key(8'h5A);
        rd(8'h07, 8'h00);
        send_bits(8'hE0, 1'b1, 11);
        send_bits(8'h05, 1'b1, 11);
        rd(8'h05, 8'h00);

        // Robustness: a bad stop bit, an abandoned frame and a clock glitch.
        send_bits(8'h1E, 1'b0, 11);
        send_bits(8'h3D, 1'b1, 4);
        #4000;
        send_bits(8'h16, 1'b1, 11);
        rd(8'h06, 8'h01);
        PS2_Clock = 1'b0; #20; PS2_Clock = 1'b1;
        #500;
        send_bits(8'h1E, 1'b1, 11);
        rd(8'h06, 8'h12);

        // F12 commits at once, and digits are locked out while Commit is set.
        send_bits(8'h07, 1'b1, 11);
        send_bits(8'h45, 1'b1, 11);
        rd(8'h08, 8'h00);
        rd(8'h05, 8'h0C); rd(8'h06, 8'h12); rd(8'h07, 8'h01);
        rd(8'h05, 8'h00); rd(8'h06, 8'h00); rd(8'h07, 8'h00);

        repeat (5) @(posedge CLK);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain got=%0d required=0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
